// File: rtl/keyboard_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keyboard_cmd_ctrl
//  Description : Turns decoded PS/2 key events into game navigation commands
//                (UP/DOWN/LEFT/RIGHT/ENTER). Direction keys auto-repeat while
//                held; commands are queued in a small circular FIFO drained
//                through a valid/ready handshake.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                key_valid         - one-cycle event strobe from the decoder
//                last_change[8:0]  - {extend, scancode} of the event
//                key_down[511:0]   - key-held bitmap (already updated)
//                cmd_valid/ready   - FIFO head handshake
//                cmd_code[2:0]     - head command (1..5), 0 when empty
//                cmd_rep           - head command came from auto-repeat
//                held_dir[2:0]     - direction armed for repeat, 0 if none
//                overflow          - sticky, a command was dropped (FIFO full)
//  Revision    : 1.0 - initial release
// ============================================================================
module keyboard_cmd_ctrl #(
    parameter int REPEAT_DELAY  = 25_000_000,  // >= 2
    parameter int REPEAT_PERIOD = 10_000_000,  // >= 2
    parameter int FIFO_DEPTH    = 4            // power of 2, >= 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [8:0]   last_change,
    input  logic [511:0] key_down,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [2:0]   cmd_code,
    output logic         cmd_rep,
    output logic [2:0]   held_dir,
    output logic         overflow
);

    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT   = (c_PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_CMD_NONE  = 3'd0;
    localparam logic [2:0] c_CMD_UP    = 3'd1;
    localparam logic [2:0] c_CMD_DOWN  = 3'd2;
    localparam logic [2:0] c_CMD_LEFT  = 3'd3;
    localparam logic [2:0] c_CMD_RIGHT = 3'd4;
    localparam logic [2:0] c_CMD_ENTER = 3'd5;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic [2:0] w_key_code;
    logic       w_key_is_dir;
    logic       w_key_press;

    always_comb begin
        w_key_code = c_CMD_NONE;
        case (last_change)
            9'h175:         w_key_code = c_CMD_UP;
            9'h172:         w_key_code = c_CMD_DOWN;
            9'h16B:         w_key_code = c_CMD_LEFT;
            9'h174:         w_key_code = c_CMD_RIGHT;
            9'h05A, 9'h15A: w_key_code = c_CMD_ENTER;
            default:        w_key_code = c_CMD_NONE;
        endcase
    end

    assign w_key_is_dir = (w_key_code != c_CMD_NONE) && (w_key_code != c_CMD_ENTER);
    assign w_key_press  = key_down[last_change];

    // ------------------------------------------------------------------
    // Repeat FSM
    // ------------------------------------------------------------------
    logic [1:0]         r_state,    w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic [2:0]         r_held_dir, w_held_dir_nxt;
    logic               w_enq;
    logic [3:0]         w_enq_data;   // {code, rep}

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_held_dir_nxt = r_held_dir;
        w_enq          = 1'b0;
        w_enq_data     = {r_held_dir, 1'b1};

        case (r_state)
            c_ST_DELAY: begin
                if (r_cnt == c_DELAY_LAST) begin
                    w_enq       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_REPEAT: begin
                if (r_cnt == c_PERIOD_LAST) begin
                    w_enq     = 1'b1;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A relevant key event overrides a coincident repeat tick: a press
        // takes the single enqueue slot, a release of the armed key cancels it.
        if (key_valid && (w_key_code != c_CMD_NONE)) begin
            if (w_key_press) begin
                w_enq      = 1'b1;
                w_enq_data = {w_key_code, 1'b0};
                if (w_key_is_dir) begin
                    w_held_dir_nxt = w_key_code;
                    w_state_nxt    = c_ST_DELAY;
                    w_cnt_nxt      = '0;
                end
            end else if ((r_held_dir != c_CMD_NONE) && (w_key_code == r_held_dir)) begin
                w_enq          = 1'b0;
                w_held_dir_nxt = c_CMD_NONE;
                w_state_nxt    = c_ST_IDLE;
                w_cnt_nxt      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_held_dir <= c_CMD_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_held_dir <= w_held_dir_nxt;
        end
    end

    assign held_dir = r_held_dir;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [3:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;
    logic               w_pop;
    logic               w_push;
    logic               w_empty;

    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && cmd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push  = w_enq && ((r_count != c_DEPTH_CNT) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_enq && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enq_data;
        end
    end

    assign cmd_valid = !w_empty;
    assign cmd_code  = w_empty ? c_CMD_NONE : r_mem[r_rd_ptr][3:1];
    assign cmd_rep   = w_empty ? 1'b0 : r_mem[r_rd_ptr][0];
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
